m72_irq_source: RTL

- Generates the eight interrupt-request lines that feed the M72 interrupt controller's intp[7:0] input.
- Vblank request: produced on the rising edge of vblank.
- Raster request: produced when the current scanline matches a CPU-programmed compare line.
- Remaining lines: external asynchronous requests, synchronised into the clk domain.
- Every request is stretched to a fixed-length level pulse, so the edge-triggered controller samples it reliably even while it is busy with an earlier request.

---
 rtl/m72_irq_source.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/m72_irq_source.sv
// -----------------------------------------------------------------------------
// m72_irq_source
//
// Builds the eight interrupt-request lines for the M72 interrupt controller.
//   - vblank request : rising edge of i_vblank
//   - raster request : start of the line whose number matches the programmed
//                      compare line (plus RASTER_OFFSET), when enabled
//   - other bits     : external asynchronous requests, synchronised to clk
// Every request is stretched to a PULSE_LEN ce-cycle level pulse so the
// edge-triggered controller cannot miss it while it is busy.
//
// Ports
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_ce           clock enable shared with the interrupt controller
//   i_vcount[8:0]  current scanline
//   i_hblank       horizontal blank
//   i_vblank       vertical blank
//   i_raster_wr    compare register write strobe (qualified by i_ce)
//   i_din[8:0]     compare register write data
//   i_raster_en    raster interrupt enable
//   i_ext_irq[7:0] asynchronous external requests (VBL_BIT/RASTER_BIT ignored)
//   o_intp[7:0]    request lines to the interrupt controller
//   o_raster_line  current compare register value
// -----------------------------------------------------------------------------
module m72_irq_source #(
    parameter int         PULSE_LEN     = 16,
    parameter logic [8:0] RASTER_OFFSET = 9'd0,
    parameter int         VBL_BIT       = 0,
    parameter int         RASTER_BIT    = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic [8:0] i_vcount,
    input  logic       i_hblank,
    input  logic       i_vblank,
    input  logic       i_raster_wr,
    input  logic [8:0] i_din,
    input  logic       i_raster_en,
    input  logic [7:0] i_ext_irq,
    output logic [7:0] o_intp,
    output logic [8:0] o_raster_line
);

    localparam logic [7:0] LP_PULSE = PULSE_LEN[7:0];

    // Bits driven by the external inputs; the two internal sources own the rest.
    localparam logic [7:0] LP_EXT_MASK = ~((8'd1 << VBL_BIT) | (8'd1 << RASTER_BIT));

    // Blank-edge registers, compare register
    logic       r_vblank_d;
    logic       r_hblank_d;
    logic [8:0] r_raster_line;

    // External request synchroniser and edge register
    logic [7:0] r_ext_meta;
    logic [7:0] r_ext_sync;
    logic [7:0] r_ext_d;

    // Per-bit pulse stretch counters
    logic [7:0] r_cnt [8];

    logic       w_vbl_evt;
    logic       w_line_evt;
    logic       w_rast_evt;
    logic [8:0] w_target;
    logic [7:0] w_ext_evt;
    logic [7:0] w_evt;

    // Blank edges are only meaningful on ce cycles, the same cycles in which
    // the delayed copies advance.
    assign w_vbl_evt  = i_ce & i_vblank & ~r_vblank_d;
    assign w_line_evt = i_ce & i_hblank & ~r_hblank_d;

    // 9-bit addition wraps naturally mod 512. The register value used here is
    // the one from before any write in this same cycle, so a coincident write
    // only takes effect from the next line.
    assign w_target   = r_raster_line + RASTER_OFFSET;
    assign w_rast_evt = w_line_evt & i_raster_en & (i_vcount == w_target);

    assign w_ext_evt  = {8{i_ce}} & r_ext_sync & ~r_ext_d & LP_EXT_MASK;

    always_comb begin
        w_evt             = w_ext_evt;
        w_evt[VBL_BIT]    = w_vbl_evt;
        w_evt[RASTER_BIT] = w_rast_evt;
    end

    // Edge registers reset to 1 so a blank already active at reset release
    // is not mistaken for a fresh edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vblank_d    <= 1'b1;
            r_hblank_d    <= 1'b1;
            r_raster_line <= 9'h1FF;
            r_ext_d       <= 8'h00;
        end else if (i_ce) begin
            r_vblank_d <= i_vblank;
            r_hblank_d <= i_hblank;
            r_ext_d    <= r_ext_sync;
            if (i_raster_wr) begin
                r_raster_line <= i_din;
            end
        end
    end

    // Synchroniser runs on every clk so metastability settling does not depend
    // on the ce rate.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ext_meta <= 8'h00;
            r_ext_sync <= 8'h00;
        end else begin
            r_ext_meta <= i_ext_irq;
            r_ext_sync <= r_ext_meta;
        end
    end

    // One stretch counter per request line. A new event reloads the counter,
    // which extends a pulse already in progress without a low glitch.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pulse
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_cnt[gi] <= 8'd0;
                end else if (i_ce) begin
                    if (w_evt[gi]) begin
                        r_cnt[gi] <= LP_PULSE;
                    end else if (r_cnt[gi] != 8'd0) begin
                        r_cnt[gi] <= r_cnt[gi] - 8'd1;
                    end
                end
            end

            assign o_intp[gi] = (r_cnt[gi] != 8'd0);
        end
    endgenerate

    assign o_raster_line = r_raster_line;

endmodule
